q_seq_driver: RTL and testbench

Stimulus-side sequencer that generates the 3-bit state vector Q3..Q1 and the carry/terminal flag C consumed by the counter-observation blocks in the lab designs. On a start command it steps an internal 3-bit counter a programmed number of times, up or down, in binary or Gray order. It reports each wrap on C and signals completion with a one-cycle Done pulse. It sits between the bench or top-level control and any block that samples Q3, Q2, Q1, C on Clk.

---
 rtl/q_seq_pkg.sv | 7 +
 rtl/q_gray_enc.sv | 9 +
 rtl/q_seq_driver.sv | 107 ++++++++++
 tb/tb_q_seq_driver.sv | 132 +++++++++++++
 4 files changed

// File: rtl/q_seq_pkg.sv
// Shared types and constants for the Q3..Q1 stimulus sequencer.
package q_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int Q_W = 3;
  localparam logic [Q_W-1:0] Q_MAX = 3'd7;
  localparam logic [Q_W-1:0] Q_MIN = 3'd0;
endpackage

// File: rtl/q_gray_enc.sv
// Combinational 3-bit binary-to-Gray converter.
module q_gray_enc
  import q_seq_pkg::*;
(
  input  logic [Q_W-1:0] bin,
  output logic [Q_W-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/q_seq_driver.sv
// Burst sequencer driving Q3..Q1 and wrap flag C; Gray output order exists
// only when Q_SEQ_GRAY_EN is defined, otherwise Q is always binary.
module q_seq_driver
  import q_seq_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [LEN_W-1:0] Len,
  input  logic             Up,
  input  logic             Mode,
  input  logic             Load,
  input  logic [Q_W-1:0]   LoadVal,
  output logic             Q3,
  output logic             Q2,
  output logic             Q1,
  output logic             C,
  output logic             Busy,
  output logic             Done
);
  state_t           state, state_nxt;
  logic [Q_W-1:0]   cnt, cnt_nxt, step, q_src, q_enc, q_r;
  logic [LEN_W-1:0] rem, rem_nxt;
  logic             up_q, wrap, c_r, done_r, zlen_q, accept;

  assign accept = (state == IDLE) && Start && (Len != '0);
  assign step   = up_q ? cnt + 3'd1 : cnt - 3'd1;
  assign wrap   = up_q ? (cnt == Q_MAX) : (cnt == Q_MIN);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rem_nxt   = rem;
    case (state)
      IDLE: begin
        if (Start) begin
          if (Len != '0) begin
            state_nxt = RUN;
            rem_nxt   = Len;
          end else begin
            state_nxt = DONE;
          end
        end else if (Load) begin
          cnt_nxt = LoadVal;
        end
      end
      RUN: begin
        cnt_nxt = step;
        rem_nxt = rem - LEN_W'(1);
        if (rem == LEN_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // During a step Q tracks the new count on the same edge; otherwise it
  // re-encodes the held count, so a Load shows one edge later.
  assign q_src = (state == RUN) ? step : cnt;

`ifdef Q_SEQ_GRAY_EN
  logic           mode_q;
  logic [Q_W-1:0] q_gray;

  q_gray_enc u_enc (.bin(q_src), .gray(q_gray));
  assign q_enc = mode_q ? q_gray : q_src;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       mode_q <= 1'b0;
    else if (accept) mode_q <= Mode;
  end
`else
  logic unused_mode;
  assign unused_mode = Mode;
  assign q_enc       = q_src;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      up_q   <= 1'b1;
      q_r    <= '0;
      c_r    <= 1'b0;
      done_r <= 1'b0;
      zlen_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rem    <= rem_nxt;
      if (accept) up_q <= Up;
      q_r    <= q_enc;
      c_r    <= (state == RUN) && wrap;
      // A zero-length burst spends its DONE cycle before the pulse appears.
      zlen_q <= (state == IDLE) && Start && (Len == '0);
      done_r <= ((state == RUN) && (rem == LEN_W'(1))) || zlen_q;
    end
  end

  assign {Q3, Q2, Q1} = q_r;
  assign C    = c_r;
  assign Busy = (state == RUN);
  assign Done = done_r;
endmodule

// File: tb/tb_q_seq_driver.sv
// Directed vector bench for q_seq_driver; expectations follow Q_SEQ_GRAY_EN.
module tb_q_seq_driver;
  logic       Clk = 1'b0, Reset = 1'b1;
  logic       Start = 1'b0, Up = 1'b0, Mode = 1'b0, Load = 1'b0;
  logic [7:0] Len = '0;
  logic [2:0] LoadVal = '0;
  logic       Q3, Q2, Q1, C, Busy, Done;
  int         checks = 0, errors = 0;

  typedef struct {
    logic       start;
    logic [7:0] len;
    logic       up, mode, load;
    logic [2:0] lv;
    logic [2:0] q;
    logic       c, busy, done;
  } vec_t;
  vec_t vecs[$];

  q_seq_driver #(.LEN_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Len(Len), .Up(Up), .Mode(Mode),
    .Load(Load), .LoadVal(LoadVal), .Q3(Q3), .Q2(Q2), .Q1(Q1), .C(C),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {Q,C,Busy,Done}=%b required %b", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {Q3, Q2, Q1, C, Busy, Done};
  endfunction

  task automatic add(input logic s, input logic [7:0] l, input logic u, input logic m,
                     input logic ld, input logic [2:0] lv, input logic [2:0] q,
                     input logic c, input logic b, input logic d);
    vec_t v;
    v.start = s; v.len = l; v.up = u; v.mode = m; v.load = ld; v.lv = lv;
    v.q = q; v.c = c; v.busy = b; v.done = d;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string name);
    Start = v.start; Len = v.len; Up = v.up; Mode = v.mode; Load = v.load; LoadVal = v.lv;
    @(posedge Clk); #1;
    chk(name, outs(), {v.q, v.c, v.busy, v.done});
  endtask

  initial begin
    logic [2:0] g [1:5];
`ifdef Q_SEQ_GRAY_EN
    g[1] = 3'b001; g[2] = 3'b011; g[3] = 3'b010; g[4] = 3'b110; g[5] = 3'b111;
`else
    g[1] = 3'b001; g[2] = 3'b010; g[3] = 3'b011; g[4] = 3'b100; g[5] = 3'b101;
`endif
    // Len=8 up, binary, from 0
    add(1, 8, 1, 0, 0, 0, 3'd0, 0, 1, 0);
    for (int i = 1; i <= 8; i++)
      add(0, 0, 0, 0, 0, 0, 3'(i), i == 8, i < 8, i == 8);
    add(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    // Load 2, then Len=3 down
    add(0, 0, 0, 0, 1, 3'd2, 3'd0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3'd2, 0, 0, 0);
    add(1, 3, 0, 0, 0, 0, 3'd2, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 3'd1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 3'd7, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 3'd7, 0, 0, 0);
    // Load 0, then Len=5 up in Gray mode
    add(0, 0, 0, 0, 1, 3'd0, 3'd7, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    add(1, 5, 1, 1, 0, 0, 3'd0, 0, 1, 0);
    for (int i = 1; i <= 5; i++)
      add(0, 0, 0, 0, 0, 0, g[i], 0, i < 5, i == 5);
    add(0, 0, 0, 0, 0, 0, g[5], 0, 0, 0);
    // Len=0: Done one edge late, nothing else moves, Up/Mode not latched
    add(1, 0, 0, 0, 0, 0, g[5], 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, g[5], 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, g[5], 0, 0, 0);
    // Start with Load together: Load ignored, 5 -> 6
    add(1, 1, 1, 0, 1, 3'd3, g[5], 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 3'd6, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 3'd6, 0, 0, 0);
    // Start/Load pulsed during RUN and DONE are ignored
    add(1, 4, 1, 0, 0, 0, 3'd6, 0, 1, 0);
    add(1, 1, 0, 1, 1, 3'd0, 3'd7, 0, 1, 0);
    add(1, 1, 0, 1, 1, 3'd0, 3'd0, 1, 1, 0);
    add(1, 1, 0, 1, 1, 3'd0, 3'd1, 0, 1, 0);
    add(1, 1, 0, 1, 1, 3'd0, 3'd2, 0, 0, 1);
    add(1, 3, 0, 1, 1, 3'd5, 3'd2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3'd2, 0, 0, 0);
    // Len=6 burst from cnt=2, reset after 3 steps
    add(1, 6, 1, 0, 0, 0, 3'd2, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 3'd3, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 3'd4, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 3'd5, 0, 1, 0);

    #12;
    chk("reset_state", outs(), 6'b0);
    @(negedge Clk); Reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    #2 Reset = 1'b1;
    #1 chk("async_reset", outs(), 6'b0);
    @(posedge Clk); #1;
    chk("reset_hold", outs(), 6'b0);
    #2 Reset = 1'b0;

    begin
      vec_t v;
      v.start = 1; v.len = 2; v.up = 1; v.mode = 0; v.load = 0; v.lv = 0;
      v.q = 3'd0; v.c = 0; v.busy = 1; v.done = 0;
      apply(v, "post_rst_start");
      v.start = 0; v.len = 0; v.q = 3'd1;
      apply(v, "post_rst_step1");
      v.q = 3'd2; v.busy = 0; v.done = 1;
      apply(v, "post_rst_step2");
      v.done = 0;
      apply(v, "post_rst_idle");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
